// File: rtl/bank_access_arb.sv
// rtl/bank_access_arb.sv - two-port arbiter and sequencer for a single-cycle SRAM bank
//
// Purpose: zero-fills the bank after reset or clear, then arbitrates host/DMA (port 0)
// and compute engine (port 1) onto the bank, one access per clock, returning read data
// one cycle after the bank access cycle.
//
// Ports:
//   clk, rst                 clock (also bank phase clock), synchronous active-high reset
//   clear                    one-cycle pulse restarting the zero-fill
//   init_done                zero-fill complete, requests accepted
//   req_valid/ready/we[1:0]  per-port request handshake and op (1 = write)
//   req_addr0/1, req_wdata0/1 per-port address and write data
//   resp_valid[1:0]          one-cycle read-data strobe for the requesting port
//   resp_rdata               shared read data, qualified by resp_valid
//   bank_cs/w_en/addr/wdata  registered bank controls
//   bank_rdata               bank sense output, valid at the edge ending a read cycle
module bank_access_arb #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    output logic              init_done,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_we,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              bank_cs,
    output logic              bank_w_en,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [DATA_W-1:0] bank_wdata,
    input  logic [DATA_W-1:0] bank_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] fill_cnt;
    logic              rr_last;
    logic [1:0]        rd_pend;   // one-hot port of a read currently in its bank cycle
    logic [1:0]        grant;
    logic              accept;
    logic              gnt_port;

    always_comb begin
        state_nxt = state;
        grant     = 2'b00;
        case (state)
            INIT: begin
                if (!clear && fill_cnt == LAST_ADDR) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (clear) begin
                    state_nxt = INIT;
                end else if (req_valid == 2'b11) begin
                    // Both contending: favour the port that did not win last.
                    grant = rr_last ? 2'b01 : 2'b10;
                end else begin
                    grant = req_valid;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    assign req_ready = grant;
    assign accept    = |grant;
    assign gnt_port  = grant[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT;
            fill_cnt   <= '0;
            rr_last    <= 1'b1;
            init_done  <= 1'b0;
            rd_pend    <= 2'b00;
            resp_valid <= 2'b00;
            resp_rdata <= '0;
            bank_cs    <= 1'b0;
            bank_w_en  <= 1'b0;
            bank_addr  <= '0;
            bank_wdata <= '0;
        end else begin
            state <= state_nxt;

            // Response path runs independently of state so a read issued just
            // before a clear still returns its data.
            resp_valid <= rd_pend;
            if (|rd_pend) begin
                resp_rdata <= bank_rdata;
            end
            rd_pend <= 2'b00;

            case (state)
                INIT: begin
                    if (clear) begin
                        fill_cnt  <= '0;
                        bank_cs   <= 1'b0;
                        bank_w_en <= 1'b0;
                    end else begin
                        bank_cs    <= 1'b1;
                        bank_w_en  <= 1'b1;
                        bank_addr  <= fill_cnt;
                        bank_wdata <= '0;
                        fill_cnt   <= fill_cnt + 1'b1;   // wraps to 0 after the last word
                        if (fill_cnt == LAST_ADDR) begin
                            init_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (clear) begin
                        fill_cnt  <= '0;
                        init_done <= 1'b0;
                        bank_cs   <= 1'b0;
                        bank_w_en <= 1'b0;
                    end else if (accept) begin
                        bank_cs    <= 1'b1;
                        bank_w_en  <= req_we[gnt_port];
                        bank_addr  <= gnt_port ? req_addr1 : req_addr0;
                        bank_wdata <= gnt_port ? req_wdata1 : req_wdata0;
                        rr_last    <= gnt_port;
                        rd_pend    <= req_we[gnt_port] ? 2'b00 : grant;
                    end else begin
                        // Idle/precharge cycle; address and data hold.
                        bank_cs   <= 1'b0;
                        bank_w_en <= 1'b0;
                    end
                end
                default: begin
                    bank_cs   <= 1'b0;
                    bank_w_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bank_access_arb.sv
// tb/tb_bank_access_arb.sv - scoreboard bench for bank_access_arb with bank model and reference model
module tb_bank_access_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        init_done;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  req_we = 2'b00;
    logic [5:0]  req_addr0 = '0, req_addr1 = '0;
    logic [31:0] req_wdata0 = '0, req_wdata1 = '0;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        bank_cs, bank_w_en;
    logic [5:0]  bank_addr;
    logic [31:0] bank_wdata, bank_rdata;

    bank_access_arb #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .clear(clear), .init_done(init_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .bank_cs(bank_cs), .bank_w_en(bank_w_en), .bank_addr(bank_addr),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
    );

    always #5 clk = ~clk;

    // Physical bank: written at the edge ending a write cycle, read combinationally
    // during a read cycle. Starts with junk so the zero-fill is observable.
    logic [31:0] mem [64];
    initial for (int i = 0; i < 64; i++) mem[i] = 32'hA5A5_0000 | i;
    always @(posedge clk) if (bank_cs && bank_w_en) mem[bank_addr] <= bank_wdata;
    assign bank_rdata = (bank_cs && !bank_w_en) ? mem[bank_addr] : 32'h0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct {
        int          due;
        logic [1:0]  port;
        logic [31:0] data;
    } resp_t;
    resp_t       expq[$];
    logic [31:0] ref_mem [64];
    bit          run;
    int          fill;
    int          last;
    bit          mon_en = 0;
    logic        exp_cs, exp_we;
    logic [5:0]  exp_addr;
    logic [31:0] exp_wdata;

    // Scoreboard monitor: consumes expected responses when they fall due.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (expq.size() > 0 && expq[0].due == cyc) begin
                resp_t e;
                e = expq.pop_front();
                chk("resp_valid", {62'b0, resp_valid}, {62'b0, e.port});
                chk("resp_rdata", {32'b0, resp_rdata}, {32'b0, e.data});
            end else begin
                chk("resp_idle", {62'b0, resp_valid}, 64'h0);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        clear = 1'b0;
        req_valid = 2'b00;
        expq.delete();
        @(negedge clk);
        chk("rst_bank_cs", {63'b0, bank_cs}, 64'h0);
        chk("rst_resp_valid", {62'b0, resp_valid}, 64'h0);
        chk("rst_init_done", {63'b0, init_done}, 64'h0);
        rst = 1'b0;
        run = 0;
        fill = 64;
        last = 1;
        exp_cs = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        mon_en = 1;
    endtask

    // One clock of stimulus; entered and left at a falling edge.
    task automatic step(input logic [1:0] v, input logic [1:0] we,
                        input logic [5:0] a0, input logic [5:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1, input logic clr);
        logic [1:0] g;
        int         p;
        req_valid = v; req_we = we; req_addr0 = a0; req_addr1 = a1;
        req_wdata0 = d0; req_wdata1 = d1; clear = clr;
        #1;
        chk("init_done", {63'b0, init_done}, {63'b0, run});
        chk("bank_cs", {63'b0, bank_cs}, {63'b0, exp_cs});
        chk("bank_w_en", {63'b0, bank_w_en}, {63'b0, exp_we});
        chk("bank_addr", {58'b0, bank_addr}, {58'b0, exp_addr});
        chk("bank_wdata", {32'b0, bank_wdata}, {32'b0, exp_wdata});
        g = 2'b00;
        if (run && !clr && v != 2'b00) begin
            if (v == 2'b11) p = (last == 0) ? 1 : 0;
            else            p = v[1] ? 1 : 0;
            g[p] = 1'b1;
        end
        chk("req_ready", {62'b0, req_ready}, {62'b0, g});
        if (!run) begin
            exp_cs = 1'b1; exp_we = 1'b1; exp_addr = 6'(64 - fill); exp_wdata = '0;
            fill--;
            if (fill == 0) run = 1;
        end else if (clr) begin
            exp_cs = 1'b0; exp_we = 1'b0;
            run = 0;
            fill = 64;
            for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        end else if (g != 2'b00) begin
            last = p;
            exp_cs = 1'b1;
            exp_we = we[p];
            exp_addr = p ? a1 : a0;
            exp_wdata = p ? d1 : d0;
            if (we[p]) ref_mem[exp_addr] = exp_wdata;
            else expq.push_back('{due: cyc + 2, port: g, data: ref_mem[exp_addr]});
        end else begin
            exp_cs = 1'b0; exp_we = 1'b0;
        end
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic rand_step(input bit allow_clear);
        logic clr;
        clr = allow_clear && run && ($urandom_range(0, 99) == 0);
        step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
             $urandom, $urandom, clr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Zero-fill with both ports requesting: no grants, addr 0..63 in order.
        for (int i = 0; i < 64; i++)
            step(2'b11, 2'b00, 6'd1, 6'd2, 32'h0, 32'h0, 1'b0);

        // Port 0 write then read of addr 5.
        step(2'b01, 2'b01, 6'd5, 6'd0, 32'hDEADBEEF, 32'h0, 1'b0);
        step(2'b01, 2'b00, 6'd5, 6'd0, 32'h0, 32'h0, 1'b0);

        // Contending reads for 6 cycles.
        for (int i = 0; i < 6; i++)
            step(2'b11, 2'b00, 6'd5, 6'(10 + i), 32'h0, 32'h0, 1'b0);

        // Port 1: unwritten top address, then write/read back-to-back.
        step(2'b10, 2'b00, 6'd0, 6'd63, 32'h0, 32'h0, 1'b0);
        step(2'b10, 2'b10, 6'd0, 6'd63, 32'h0, 32'h1234_5678, 1'b0);
        step(2'b10, 2'b00, 6'd0, 6'd63, 32'h0, 32'h0, 1'b0);
        idle(2);

        // Clear right after a read grant; earlier data must come back as zero.
        step(2'b01, 2'b00, 6'd5, 6'd0, 32'h0, 32'h0, 1'b0);
        step(2'b11, 2'b00, 6'd5, 6'd63, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 64; i++) rand_step(0);
        step(2'b01, 2'b00, 6'd5, 6'd0, 32'h0, 32'h0, 1'b0);
        step(2'b10, 2'b00, 6'd0, 6'd63, 32'h0, 32'h0, 1'b0);

        // Randomized traffic with occasional clears.
        for (int i = 0; i < 400; i++) rand_step(1);
        while (!run) rand_step(0);
        idle(2);

        // Reset mid-fill.
        do_reset();
        for (int i = 0; i < 20; i++) idle(1);
        do_reset();
        for (int i = 0; i < 64; i++) rand_step(0);

        // Reset in the cycle after a read grant: response is dropped.
        step(2'b01, 2'b00, 6'd3, 6'd0, 32'h0, 32'h0, 1'b0);
        do_reset();
        for (int i = 0; i < 64; i++) idle(1);
        for (int i = 0; i < 50; i++) rand_step(0);
        idle(3);

        chk("queue_drained", 64'(expq.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
